// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory master: modeBU encodings, FSM states
// and size/lane helper functions.
package lsu_pkg;

    localparam logic [2:0] MODE_W  = 3'b001;
    localparam logic [2:0] MODE_H  = 3'b010;
    localparam logic [2:0] MODE_B  = 3'b011;
    localparam logic [2:0] MODE_HU = 3'b100;
    localparam logic [2:0] MODE_BU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [2:0] size_of(input logic [2:0] mode);
        case (mode)
            MODE_W:          return 3'd4;
            MODE_H, MODE_HU: return 3'd2;
            MODE_B, MODE_BU: return 3'd1;
            default:         return 3'd0;
        endcase
    endfunction

    function automatic logic is_legal(input logic [2:0] mode);
        return (size_of(mode) != 3'd0);
    endfunction

    // Byte-enable pattern of an n-byte access starting at lane 3 (most-significant lane).
    function automatic logic [3:0] size_mask(input logic [2:0] size);
        case (size)
            3'd4:    return 4'b1111;
            3'd2:    return 4'b1100;
            3'd1:    return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [4:0] rjust_shift(input logic [2:0] size);
        case (size)
            3'd2:    return 5'd16;
            3'd1:    return 5'd24;
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic [31:0] byte_mask(input logic [3:0] be);
        logic [31:0] m;
        m = 32'h0;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/lsu_mem_master_lane_align.sv
// Big-endian lane placement: splits an access into up to two word beats and
// produces per-beat byte enables and lane-placed, zero-filled write data.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [2:0]  size,
    input  logic [31:0] wdata,
    output logic        split,
    output logic [3:0]  be0,
    output logic [3:0]  be1,
    output logic [31:0] wdata0,
    output logic [31:0] wdata1
);

    logic [31:0] wd_lj_s;
    logic [63:0] wd_win_s;
    logic [7:0]  be_win_s;

    // Left-justify the data, then slide an 8-byte window right by the offset.
    always_comb begin
        wd_lj_s  = wdata << rjust_shift(size);
        wd_win_s = {wd_lj_s, 32'h0} >> {offset, 3'b000};
        be_win_s = {size_mask(size), 4'h0} >> offset;
    end

    assign be0    = be_win_s[7:4];
    assign be1    = be_win_s[3:0];
    assign wdata0 = wd_win_s[63:32];
    assign wdata1 = wd_win_s[31:0];
    assign split  = |be_win_s[3:0];

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator: one request at a time, issued as one or two word beats on a
// handshaked memory bus, with load reassembly and sign/zero extension.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_mode,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err,
    output logic             mem_valid,
    input  logic             mem_ready,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [3:0]       mem_be,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_rvalid,
    input  logic [WIDTH-1:0] mem_rdata
);

    state_t      state_r, state_s;
    logic        we_r, we_s;
    logic [2:0]  mode_r, mode_s;
    logic [29:0] base_r, base_s;
    logic [1:0]  off_r, off_s;
    logic [31:0] wdata_r, wdata_s;
    logic        beat_r, beat_s;
    logic [63:0] asm_r, asm_s;

    logic        req_ready_r, req_ready_s;
    logic        resp_valid_r, resp_valid_s;
    logic [31:0] resp_rdata_r, resp_rdata_s;
    logic        resp_err_r, resp_err_s;
    logic        mem_valid_r, mem_valid_s;
    logic        mem_we_r, mem_we_s;
    logic [31:0] mem_addr_r, mem_addr_s;
    logic [3:0]  mem_be_r, mem_be_s;
    logic [31:0] mem_wdata_r, mem_wdata_s;

    logic [1:0]  al_off_s;
    logic [2:0]  al_size_s;
    logic [31:0] al_wdata_s;
    logic        split_s;
    logic [3:0]  be0_s, be1_s;
    logic [31:0] wd0_s, wd1_s;

    // Undo the lane placement and extend according to the modeBU encoding.
    function automatic logic [31:0] load_result(input logic [63:0] win, input logic [1:0] off,
                                                input logic [2:0] mode);
        logic [31:0] rj;
        rj = 32'((win << {off, 3'b000}) >> 32) >> rjust_shift(size_of(mode));
        case (mode)
            MODE_W:  return rj;
            MODE_H:  return {{16{rj[15]}}, rj[15:0]};
            MODE_B:  return {{24{rj[7]}}, rj[7:0]};
            MODE_HU: return {16'h0, rj[15:0]};
            MODE_BU: return {24'h0, rj[7:0]};
            default: return 32'h0;
        endcase
    endfunction

    // While idle the aligner sees the incoming request so beat0 can be launched on accept.
    assign al_off_s   = (state_r == IDLE) ? req_addr[1:0] : off_r;
    assign al_size_s  = (state_r == IDLE) ? size_of(req_mode) : size_of(mode_r);
    assign al_wdata_s = (state_r == IDLE) ? req_wdata : wdata_r;

    lsu_lane_align u_align (
        .offset (al_off_s),
        .size   (al_size_s),
        .wdata  (al_wdata_s),
        .split  (split_s),
        .be0    (be0_s),
        .be1    (be1_s),
        .wdata0 (wd0_s),
        .wdata1 (wd1_s)
    );

    // Next-state, next-output and load-assembly logic.
    always_comb begin
        state_s      = state_r;
        we_s         = we_r;
        mode_s       = mode_r;
        base_s       = base_r;
        off_s        = off_r;
        wdata_s      = wdata_r;
        beat_s       = beat_r;
        asm_s        = asm_r;
        req_ready_s  = req_ready_r;
        resp_valid_s = 1'b0;
        resp_err_s   = 1'b0;
        resp_rdata_s = 32'h0;
        mem_valid_s  = mem_valid_r;
        mem_we_s     = mem_we_r;
        mem_addr_s   = mem_addr_r;
        mem_be_s     = mem_be_r;
        mem_wdata_s  = mem_wdata_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    req_ready_s = 1'b0;
                    we_s        = req_we;
                    mode_s      = req_mode;
                    base_s      = req_addr[31:2];
                    off_s       = req_addr[1:0];
                    wdata_s     = req_wdata;
                    beat_s      = 1'b0;
                    asm_s       = 64'h0;
                    if (is_legal(req_mode)) begin
                        state_s     = ISSUE;
                        mem_valid_s = 1'b1;
                        mem_we_s    = req_we;
                        mem_addr_s  = {req_addr[31:2], 2'b00};
                        mem_be_s    = be0_s;
                        mem_wdata_s = req_we ? wd0_s : 32'h0;
                    end else begin
                        state_s      = DONE;
                        resp_valid_s = 1'b1;
                        resp_err_s   = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (mem_ready) begin
                    mem_valid_s = 1'b0;
                    mem_we_s    = 1'b0;
                    mem_addr_s  = 32'h0;
                    mem_be_s    = 4'h0;
                    mem_wdata_s = 32'h0;
                    if (!we_r) begin
                        state_s = WAIT;
                    end else if (!beat_r && split_s) begin
                        state_s     = ISSUE;
                        beat_s      = 1'b1;
                        mem_valid_s = 1'b1;
                        mem_we_s    = 1'b1;
                        mem_addr_s  = {base_r + 30'd1, 2'b00};
                        mem_be_s    = be1_s;
                        mem_wdata_s = wd1_s;
                    end else begin
                        state_s      = DONE;
                        resp_valid_s = 1'b1;
                    end
                end else begin
                    state_s = ISSUE;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    if (beat_r) begin
                        asm_s[31:0] = mem_rdata & byte_mask(be1_s);
                    end else begin
                        asm_s[63:32] = mem_rdata & byte_mask(be0_s);
                    end
                    if (!beat_r && split_s) begin
                        state_s     = ISSUE;
                        beat_s      = 1'b1;
                        mem_valid_s = 1'b1;
                        mem_we_s    = 1'b0;
                        mem_addr_s  = {base_r + 30'd1, 2'b00};
                        mem_be_s    = be1_s;
                        mem_wdata_s = 32'h0;
                    end else begin
                        state_s      = DONE;
                        resp_valid_s = 1'b1;
                        resp_rdata_s = load_result(asm_s, off_r, mode_r);
                    end
                end else begin
                    state_s = WAIT;
                end
            end
            DONE: begin
                state_s     = IDLE;
                req_ready_s = 1'b1;
            end
            default: begin
                state_s     = IDLE;
                req_ready_s = 1'b1;
                mem_valid_s = 1'b0;
            end
        endcase
    end

    // State, request capture and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            we_r         <= 1'b0;
            mode_r       <= 3'b000;
            base_r       <= 30'h0;
            off_r        <= 2'b00;
            wdata_r      <= 32'h0;
            beat_r       <= 1'b0;
            asm_r        <= 64'h0;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'h0;
            resp_err_r   <= 1'b0;
            mem_valid_r  <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= 32'h0;
            mem_be_r     <= 4'h0;
            mem_wdata_r  <= 32'h0;
        end else begin
            state_r      <= state_s;
            we_r         <= we_s;
            mode_r       <= mode_s;
            base_r       <= base_s;
            off_r        <= off_s;
            wdata_r      <= wdata_s;
            beat_r       <= beat_s;
            asm_r        <= asm_s;
            req_ready_r  <= req_ready_s;
            resp_valid_r <= resp_valid_s;
            resp_rdata_r <= resp_rdata_s;
            resp_err_r   <= resp_err_s;
            mem_valid_r  <= mem_valid_s;
            mem_we_r     <= mem_we_s;
            mem_addr_r   <= mem_addr_s;
            mem_be_r     <= mem_be_s;
            mem_wdata_r  <= mem_wdata_s;
        end
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;
    assign mem_valid  = mem_valid_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_be     = mem_be_r;
    assign mem_wdata  = mem_wdata_r;

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
Load/store initiator between the single-cycle core's execute stage and a word-wide, handshaked data memory. It takes one load or store request using the team's modeBU size/sign encoding. It generates word-aligned bus beats with byte enables and big-endian lane placement, splitting word-crossing accesses into two beats. For loads it reassembles, sign- or zero-extends and returns the data. The core stalls while req_ready is low.

Parameters:
WIDTH, 32, data/address width; only 32 supported.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
req_valid  in  1  core request present
req_ready  out  1  unit idle, request accepted when req_valid&&req_ready
req_we  in  1  1=store, 0=load
req_mode  in  3  modeBU: 001 word, 010 half, 011 byte, 100 half unsigned, 101 byte unsigned
req_addr  in  WIDTH  byte address
req_wdata  in  WIDTH  store data, right-justified
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  WIDTH  extended load data; 0 for stores/errors
resp_err  out  1  illegal mode, valid with resp_valid
mem_valid  out  1  bus beat request
mem_ready  in  1  memory accepts beat
mem_we  out  1  beat is write
mem_addr  out  WIDTH  word-aligned address, [1:0]=0
mem_be  out  4  byte enables, bit i = bits [8i+7:8i]
mem_wdata  out  WIDTH  lane-placed write data
mem_rvalid  in  1  read data valid, one per accepted read beat
mem_rdata  in  WIDTH  read word

Behaviour:
- Reset (async): state IDLE; req_ready=1; resp_valid, resp_err, mem_valid, mem_we=0; mem_addr, mem_be, mem_wdata, resp_rdata=0. Reset mid-transaction drops it silently. The bus must be reset together.
- Byte order is big-endian. Address offset o maps to lane 3-o. An n-byte access at address a places its most-significant data byte at a and the least-significant byte at a+n-1.
- Size: word=4, half=2, byte=1. The access splits into two beats when offset+n>4. Beat0 covers word a&~3 from offset to 3. Beat1 covers word (a&~3)+4 from lane 3 downward for the remaining bytes. Address wraps mod 2^32.
- FSM IDLE/ISSUE/WAIT/DONE:
  - IDLE: req_ready=1. On handshake, register all request fields. Legal mode -> ISSUE beat0. Illegal mode (000/110/111) -> DONE with err.
  - ISSUE: mem_valid=1 with mem_we/addr/be/wdata held stable until mem_ready. On mem_ready: load -> WAIT; store with beat1 pending -> ISSUE beat1; otherwise -> DONE.
  - WAIT: on mem_rvalid, capture enabled lanes into the assembly register. Beat1 pending -> ISSUE beat1, else DONE.
  - DONE: resp_valid=1 for exactly one cycle with resp_rdata/resp_err, then IDLE. req_ready is low in DONE (no same-cycle re-accept).
- Load result: assembled n bytes, right-justified. Modes 010/011 sign-extend from the top assembled bit; 100/101 zero-extend.
- mem_rvalid outside WAIT is ignored. mem_ready outside ISSUE is ignored.
- Latency, zero-wait bus:
  - Aligned store: accept c0, ISSUE c1, resp_valid c2.
  - Aligned load with rvalid one cycle after handshake: resp_valid c3.
  - Each extra beat adds 1 cycle (store) or 2 cycles (load).
  - Illegal mode: resp_valid c1.
- mem_wdata bytes in disabled lanes are driven 0.

Decomposition:
- Package lsu_pkg: modeBU localparams (MODE_W, MODE_H, MODE_B, MODE_HU, MODE_BU), state enum, size_of(mode) and is_legal(mode) functions.
- One sub-module, lsu_lane_align: combinational. It computes the beat-split flag, per-beat mem_be, and per-beat lane-placed wdata from offset, size and wdata. The FSM and load assembly stay in the top.

Test Plan:
- Aligned store: sw 0x11223344 @0x100, mem_ready=1 -> one beat: addr 0x100, be 1111, wdata 0x11223344, we=1; resp_valid at c2, rdata 0.
- Byte loads: word@0x100=0xAA80CCDD.
  - lb @0x101 -> beat addr 0x100, be 0100; resp_rdata 0xFFFFFF80.
  - lbu @0x101 -> 0x00000080.
  - lhu @0x102 -> 0x0000CCDD.
- Split load: word@0x100=0x11223344, @0x104=0x55667788; lw @0x102 -> beats (0x100, be 0011) then (0x104, be 1100); resp_rdata 0x33445566.
- Split store: sh 0x0000BEEF @0x103 -> beat0 addr 0x100, be 0001, wdata 0x000000BE; beat1 addr 0x104, be 1000, wdata 0xEF000000.
- Backpressure and errors:
  - mem_ready low 3 cycles during ISSUE -> mem_* held stable, req_ready stays 0.
  - mode 111 -> no mem_valid; resp_err=1 at c1.
- Reset: assert rst while in WAIT -> outputs immediately reset values, req_ready=1. A late mem_rvalid afterwards produces no resp_valid.
